// File: rtl/hbridge_pkg.sv
// Shared definitions for the H-bridge gate sequencer: state encodings, fixed gate
// patterns and MOSFET bit positions within the 4-bit gate vector.
package hbridge_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StBoot  = 3'b001,
        StForce = 3'b010,
        StRun   = 3'b011,
        StFault = 3'b100
    } hb_state_e;

    localparam logic [3:0] GATE_OFF    = 4'b0000;
    localparam logic [3:0] GATE_BOOT   = 4'b1100;
    localparam logic [3:0] GATE_SIGMA1 = 4'b1001;

    // Leg 1 = M1 (high) / M3 (low); leg 2 = M2 (high) / M4 (low).
    localparam int unsigned M1 = 0;
    localparam int unsigned M2 = 1;
    localparam int unsigned M3 = 2;
    localparam int unsigned M4 = 3;

endpackage

// File: rtl/shoot_through_check.sv
// Combinational shoot-through detector: flags a gate vector that turns on both
// switches of either leg and reports which leg(s) are affected.
module shoot_through_check
    import hbridge_pkg::*;
(
    input  logic [3:0] gate_i,
    output logic       illegal_o,
    output logic [1:0] leg_code_o
);

    logic leg1_short;
    logic leg2_short;

    assign leg1_short = gate_i[M1] & gate_i[M3];
    assign leg2_short = gate_i[M2] & gate_i[M4];

    assign leg_code_o = {leg2_short, leg1_short};
    assign illegal_o  = leg1_short | leg2_short;

endmodule

// File: rtl/hbridge_gate_sequencer.sv
// Start-up sequencer and registered shoot-through guard between the dead-time
// inserter and the H-bridge gate pins: IDLE -> BOOT -> FORCE -> RUN, latching FAULT.
module hbridge_gate_sequencer
    import hbridge_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES  = 1000,
    parameter int unsigned FORCE_CYCLES = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [3:0] i_gate,
    input  logic       i_fault_clear,
    output logic [3:0] o_Q,
    output logic [2:0] o_state,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    localparam logic [CNT_W-1:0] BootLast  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ForceLast = CNT_W'(FORCE_CYCLES - 1);

    hb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       q_q, q_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;

    logic             gate_illegal;
    logic [1:0]       gate_leg_code;

    shoot_through_check u_shoot_through_check (
        .gate_i     (i_gate),
        .illegal_o  (gate_illegal),
        .leg_code_o (gate_leg_code)
    );

    // Saturate rather than wrap so a stuck phase can never alias a terminal count.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        unique case (state_q)
            StIdle: begin
                if (i_enable) begin
                    state_d = StBoot;
                    cnt_d   = '0;
                end
            end
            StBoot: begin
                if (!i_enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == BootLast) begin
                    state_d = StForce;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StForce: begin
                if (!i_enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == ForceLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRun: begin
                // A shoot-through request outranks a simultaneous disable.
                if (gate_illegal) begin
                    state_d = StFault;
                    code_d  = gate_leg_code;
                end else if (!i_enable) begin
                    state_d = StIdle;
                end
                cnt_d = '0;
            end
            StFault: begin
                if (i_fault_clear && !i_enable) begin
                    state_d = StIdle;
                    code_d  = 2'b00;
                end
                cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                code_d  = 2'b00;
            end
        endcase

        fault_d = (state_d == StFault);

        // Drive pattern follows the state being entered so o_Q stays fully registered.
        unique case (state_d)
            StBoot:  q_d = GATE_BOOT;
            StForce: q_d = GATE_SIGMA1;
            StRun:   q_d = gate_illegal ? GATE_OFF : i_gate;
            default: q_d = GATE_OFF;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= GATE_OFF;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign o_Q          = q_q;
    assign o_state      = state_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// Randomised and directed bench for hbridge_gate_sequencer against a phase-age
// reference model (cycles elapsed since leaving IDLE).
module tb_hbridge_gate_sequencer;

    localparam int unsigned Boot  = 10;
    localparam int unsigned Force = 5;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] gate;
    logic       fault_clear;
    logic [3:0] q;
    logic [2:0] state;
    logic       fault;
    logic [1:0] fault_code;

    int checks   = 0;
    int failures = 0;

    // Reference model: age < 0 means idle; otherwise phase follows from age.
    int         m_age;
    bit         m_fault;
    logic [1:0] m_code;
    logic [3:0] m_prev_gate;

    hbridge_gate_sequencer #(
        .BOOT_CYCLES  (Boot),
        .FORCE_CYCLES (Force),
        .CNT_W        (16)
    ) dut (
        .i_clock       (clk),
        .i_RESET       (rst_n),
        .i_enable      (enable),
        .i_gate        (gate),
        .i_fault_clear (fault_clear),
        .o_Q           (q),
        .o_state       (state),
        .o_fault       (fault),
        .o_fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [3:0] g);
        return (g[0] & g[2]) | (g[1] & g[3]);
    endfunction

    function automatic int phase_of(input int age);
        if (age < 0) return 0;
        if (age < int'(Boot)) return 1;
        if (age < int'(Boot + Force)) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_age       = -1;
        m_fault     = 1'b0;
        m_code      = 2'b00;
        m_prev_gate = 4'b0000;
    endtask

    task automatic model_step(input logic en, input logic [3:0] g, input logic clr);
        if (m_fault) begin
            if (clr && !en) begin
                m_fault = 1'b0;
                m_code  = 2'b00;
                m_age   = -1;
            end
        end else if (m_age < 0) begin
            if (en) m_age = 0;
        end else if (phase_of(m_age) == 3 && is_illegal(g)) begin
            m_fault = 1'b1;
            m_code  = {g[1] & g[3], g[0] & g[2]};
        end else if (!en) begin
            m_age = -1;
        end else if (m_age < 1000000) begin
            m_age++;
        end
        m_prev_gate = g;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_q;
        logic [2:0] exp_state;
        if (m_fault) begin
            exp_state = 3'b100;
            exp_q     = 4'b0000;
        end else begin
            exp_state = 3'(phase_of(m_age));
            case (phase_of(m_age))
                1:       exp_q = 4'b1100;
                2:       exp_q = 4'b1001;
                3:       exp_q = is_illegal(m_prev_gate) ? 4'b0000 : m_prev_gate;
                default: exp_q = 4'b0000;
            endcase
        end
        check_eq({tag, ".q"}, 32'(q), 32'(exp_q));
        check_eq({tag, ".state"}, 32'(state), 32'(exp_state));
        check_eq({tag, ".fault"}, 32'(fault), 32'(m_fault));
        check_eq({tag, ".code"}, 32'(fault_code), 32'(m_code));
    endtask

    task automatic cyc(input string tag, input logic en, input logic [3:0] g, input logic clr);
        enable      = en;
        gate        = g;
        fault_clear = clr;
        @(posedge clk);
        model_step(en, g, clr);
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #2;
        rst_n = 1'b1;
    endtask

    logic [3:0] legal_list [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h9, 4'h6};

    initial begin
        enable      = 1'b0;
        gate        = 4'b0000;
        fault_clear = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        rst_n = 1'b1;

        cyc("idle_illegal", 1'b0, 4'b1111, 1'b0);
        for (int i = 0; i < 15; i++) cyc("startup", 1'b1, 4'b1111, 1'b0);
        cyc("run_first", 1'b1, 4'b0001, 1'b0);
        cyc("run_seq", 1'b1, 4'b1000, 1'b0);
        cyc("run_seq", 1'b1, 4'b0010, 1'b0);
        cyc("run_seq", 1'b1, 4'b0100, 1'b0);
        cyc("run_seq", 1'b1, 4'b0000, 1'b0);
        cyc("fault_leg1", 1'b1, 4'b0101, 1'b0);
        cyc("fault_hold", 1'b1, 4'b1010, 1'b0);
        cyc("clr_while_en", 1'b1, 4'b0000, 1'b1);
        cyc("clr_ok", 1'b0, 4'b0000, 1'b1);
        cyc("idle_clr", 1'b0, 4'b0000, 1'b1);

        cyc("boot_abort", 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) cyc("boot_abort", 1'b1, 4'b0000, 1'b0);
        cyc("boot_drop", 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 13; i++) cyc("reboot", 1'b1, 4'b1111, 1'b0);
        async_reset("rst_force");

        for (int i = 0; i < 16; i++) cyc("to_run", 1'b1, 4'b0000, 1'b0);
        cyc("fault_both", 1'b0, 4'b1111, 1'b0);
        cyc("fault_stay", 1'b0, 4'b0000, 1'b0);
        async_reset("rst_fault");
        cyc("post_rst", 1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            logic       en;
            logic [3:0] g;
            logic       clr;
            en  = ($urandom_range(0, 99) < 96);
            g   = ($urandom_range(0, 99) < 92) ? legal_list[$urandom_range(0, 8)]
                                               : 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 99) < 30);
            if (m_fault && $urandom_range(0, 9) < 3) en = 1'b0;
            cyc("rand", en, g, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
